// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard/forwarding controller: rs2 forwarding, load-use bubbles,
// memory-wait freeze, two-cycle redirect flush sequencing, saturating counters.
module hazard_ctrl_unit (
  input  logic        Clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_need_rs1,
  input  logic        IFid__Need_Rs2,
  input  logic        ex_valid,
  input  logic        ex_we,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rds,
  input  logic [31:0] ex_result,
  input  logic        ma_valid,
  input  logic        ma_we,
  input  logic [4:0]  ma_rds,
  input  logic [31:0] ma_result,
  input  logic        wb_valid,
  input  logic        wb_we,
  input  logic [4:0]  wb_rds,
  input  logic [31:0] wb_data,
  input  logic        mem_busy,
  input  logic        ex_redirect,
  output logic [31:0] fwdRS2,
  output logic        fwdRS2_Sel,
  output logic        front_stall,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        ifid_flush,
  output logic        back_stall,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEMWAIT, REDIR} stT;

  typedef struct packed {
    logic frontStall;
    logic idexStall;
    logic idexFlush;
    logic ifidFlush;
    logic backStall;
  } ctlT;

  stT   st, stNext;
  logic pendRedir, pendNext;
  logic flushInc;
  ctlT  ctl;
  logic [31:0] fwdData;
  logic        fwdHit;
  logic        lu, redirAcc;
  logic [15:0] stallCnt, flushCnt;

  // Forwarding: youngest producer wins; EX loads have no data yet
  always_comb begin
    fwdData = 32'd0;
    fwdHit  = 1'b0;
    if (id_valid && IFid__Need_Rs2 && id_rs2 != 5'd0) begin
      if (ex_valid && ex_we && !ex_is_load && ex_rds == id_rs2) begin
        fwdData = ex_result;
        fwdHit  = 1'b1;
      end else if (ma_valid && ma_we && ma_rds == id_rs2) begin
        fwdData = ma_result;
        fwdHit  = 1'b1;
      end else if (wb_valid && wb_we && wb_rds == id_rs2) begin
        fwdData = wb_data;
        fwdHit  = 1'b1;
      end
    end
  end

  assign lu = id_valid && ex_valid && ex_we && ex_is_load && ex_rds != 5'd0 &&
              ((id_need_rs1 && id_rs1 == ex_rds) || (IFid__Need_Rs2 && id_rs2 == ex_rds));

  // A redirect seen while frozen is replayed on the first unfrozen cycle
  assign redirAcc = ex_redirect || (st == MEMWAIT && pendRedir);

  always_comb begin
    ctl      = '0;
    stNext   = RUN;
    pendNext = 1'b0;
    flushInc = 1'b0;
    if (mem_busy) begin
      ctl.frontStall = 1'b1;
      ctl.idexStall  = 1'b1;
      ctl.backStall  = 1'b1;
      pendNext       = pendRedir || ex_redirect;
      stNext         = MEMWAIT;
    end else if (redirAcc) begin
      ctl.ifidFlush = 1'b1;
      ctl.idexFlush = 1'b1;
      flushInc      = 1'b1;
      stNext        = REDIR;
    end else begin
      // Second flush cycle covers fetch's one-cycle PC update latency
      if (st == REDIR) ctl.ifidFlush = 1'b1;
      if (lu) begin
        ctl.frontStall = 1'b1;
        ctl.idexFlush  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      st        <= RUN;
      pendRedir <= 1'b0;
      stallCnt  <= 16'd0;
      flushCnt  <= 16'd0;
    end else begin
      st        <= stNext;
      pendRedir <= pendNext;
      if (ctl.frontStall && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
      if (flushInc && flushCnt != 16'hFFFF)       flushCnt <= flushCnt + 16'd1;
    end
  end

  assign front_stall = reset & ctl.frontStall;
  assign idex_stall  = reset & ctl.idexStall;
  assign idex_flush  = reset & ctl.idexFlush;
  assign ifid_flush  = reset & ctl.ifidFlush;
  assign back_stall  = reset & ctl.backStall;
  assign fwdRS2_Sel  = reset & fwdHit;
  assign fwdRS2      = reset ? fwdData : 32'd0;
  assign stall_count = stallCnt;
  assign flush_count = flushCnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with hand-computed expectations.
module tb_hazard_ctrl_unit;

  logic        Clk = 1'b0;
  logic        reset;
  logic        id_valid, id_need_rs1, IFid__Need_Rs2;
  logic [4:0]  id_rs1, id_rs2;
  logic        ex_valid, ex_we, ex_is_load;
  logic [4:0]  ex_rds;
  logic [31:0] ex_result;
  logic        ma_valid, ma_we;
  logic [4:0]  ma_rds;
  logic [31:0] ma_result;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rds;
  logic [31:0] wb_data;
  logic        mem_busy, ex_redirect;
  logic [31:0] fwdRS2;
  logic        fwdRS2_Sel;
  logic        front_stall, idex_stall, idex_flush, ifid_flush, back_stall;
  logic [15:0] stall_count, flush_count;

  int checks = 0;
  int failures = 0;

  hazard_ctrl_unit dut (
    .Clk(Clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_need_rs1(id_need_rs1), .IFid__Need_Rs2(IFid__Need_Rs2),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_rds(ex_rds), .ex_result(ex_result),
    .ma_valid(ma_valid), .ma_we(ma_we), .ma_rds(ma_rds), .ma_result(ma_result),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rds(wb_rds), .wb_data(wb_data),
    .mem_busy(mem_busy), .ex_redirect(ex_redirect),
    .fwdRS2(fwdRS2), .fwdRS2_Sel(fwdRS2_Sel),
    .front_stall(front_stall), .idex_stall(idex_stall), .idex_flush(idex_flush),
    .ifid_flush(ifid_flush), .back_stall(back_stall),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 Clk = ~Clk;

  // {front_stall, idex_stall, idex_flush, ifid_flush, back_stall}
  wire [4:0] ctl = {front_stall, idex_stall, idex_flush, ifid_flush, back_stall};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_valid = 0; id_need_rs1 = 0; IFid__Need_Rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_rds = 0; ex_result = 0;
    ma_valid = 0; ma_we = 0; ma_rds = 0; ma_result = 0;
    wb_valid = 0; wb_we = 0; wb_rds = 0; wb_data = 0;
    mem_busy = 0; ex_redirect = 0;
  endtask

  task automatic cyc();
    @(posedge Clk); #1;
  endtask

  task automatic fwdAll5();
    id_valid = 1; IFid__Need_Rs2 = 1; id_rs2 = 5;
    ex_valid = 1; ex_we = 1; ex_rds = 5; ex_result = 32'h11;
    ma_valid = 1; ma_we = 1; ma_rds = 5; ma_result = 32'h22;
    wb_valid = 1; wb_we = 1; wb_rds = 5; wb_data = 32'h33;
  endtask

  task automatic loadUse7();
    id_valid = 1; id_need_rs1 = 1; id_rs1 = 7;
    ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_rds = 7;
  endtask

  initial begin
    clr();
    reset = 0;
    fwdAll5();
    ex_redirect = 1;
    #2;
    chk("rst_ctl", 32'(ctl), 32'h0);
    chk("rst_sel", 32'(fwdRS2_Sel), 32'h0);
    chk("rst_fwd", fwdRS2, 32'h0);
    chk("rst_cnt", {stall_count, flush_count}, 32'h0);
    cyc(); cyc();
    clr();
    reset = 1;
    cyc();

    // forwarding priority
    fwdAll5(); #1;
    chk("fwd_ex", fwdRS2, 32'h11);
    chk("fwd_ex_sel", 32'(fwdRS2_Sel), 32'h1);
    chk("fwd_ex_ctl", 32'(ctl), 32'h0);
    ex_valid = 0; #1;
    chk("fwd_ma", fwdRS2, 32'h22);
    ma_valid = 0; #1;
    chk("fwd_wb", fwdRS2, 32'h33);
    ex_valid = 1; ma_valid = 1; id_rs2 = 0; #1;
    chk("fwd_r0_sel", 32'(fwdRS2_Sel), 32'h0);
    chk("fwd_r0_data", fwdRS2, 32'h0);
    clr(); cyc();

    // load-use bubble then MA forward
    loadUse7(); #1;
    chk("lu_ctl", 32'(ctl), 32'h14);
    cyc();
    clr();
    id_valid = 1; IFid__Need_Rs2 = 1; id_rs2 = 7;
    ma_valid = 1; ma_we = 1; ma_rds = 7; ma_result = 32'hAB; #1;
    chk("lu_fwd", fwdRS2, 32'hAB);
    chk("lu_fwd_sel", 32'(fwdRS2_Sel), 32'h1);
    chk("lu_after_ctl", 32'(ctl), 32'h0);
    chk("lu_stall_cnt", 32'(stall_count), 32'd1);
    clr(); cyc();

    // redirect in RUN
    ex_redirect = 1; #1;
    chk("redir_c0", 32'(ctl), 32'h06);
    cyc(); ex_redirect = 0; #1;
    chk("redir_c1", 32'(ctl), 32'h02);
    cyc();
    chk("redir_c2", 32'(ctl), 32'h0);
    chk("redir_fcnt", 32'(flush_count), 32'd1);

    // mem_busy 3 cycles with redirect in the 2nd
    mem_busy = 1; #1;
    chk("mb_c0", 32'(ctl), 32'h19);
    cyc(); ex_redirect = 1; #1;
    chk("mb_c1", 32'(ctl), 32'h19);
    cyc(); ex_redirect = 0; #1;
    chk("mb_c2", 32'(ctl), 32'h19);
    cyc(); mem_busy = 0; #1;
    chk("mb_replay", 32'(ctl), 32'h06);
    chk("mb_scnt", 32'(stall_count), 32'd4);
    cyc();
    chk("mb_redir2", 32'(ctl), 32'h02);
    chk("mb_fcnt", 32'(flush_count), 32'd2);
    cyc();
    chk("mb_idle", 32'(ctl), 32'h0);

    // mem_busy with load-use: freeze first, bubble when it drops
    mem_busy = 1; loadUse7(); #1;
    chk("mblu_c0", 32'(ctl), 32'h19);
    cyc(); mem_busy = 0; #1;
    chk("mblu_c1", 32'(ctl), 32'h14);
    cyc(); clr(); #1;
    chk("mblu_idle", 32'(ctl), 32'h0);
    chk("mblu_scnt", 32'(stall_count), 32'd6);

    // saturation
    mem_busy = 1;
    repeat (70000) cyc();
    chk("sat_scnt", 32'(stall_count), 32'hFFFF);
    mem_busy = 0;
    cyc();
    chk("sat_hold", 32'(stall_count), 32'hFFFF);
    ex_redirect = 1;
    cyc(); ex_redirect = 0; #1;
    chk("pre_rst_redir", 32'(ctl), 32'h02);
    chk("pre_rst_fcnt", 32'(flush_count), 32'd3);

    // reset mid-REDIR
    reset = 0; fwdAll5(); #1;
    chk("mrst_ctl", 32'(ctl), 32'h0);
    chk("mrst_sel", 32'(fwdRS2_Sel), 32'h0);
    chk("mrst_cnt", {stall_count, flush_count}, 32'h0);
    cyc();
    clr(); reset = 1;
    cyc();
    chk("post_rst_ctl", 32'(ctl), 32'h0);
    ex_redirect = 1; #1;
    chk("post_rst_redir", 32'(ctl), 32'h06);
    cyc(); ex_redirect = 0; #1;
    chk("post_rst_fcnt", 32'(flush_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
